// File: rtl/bcd_pkg.sv
// Shared BCD digit definitions for the cascaded up/down counters and display path.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Saturate an illegal nibble (A..F) to the largest legal digit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: parallel load, or step 0->9 / d->d-1 on request.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t d_in,
    input  logic       step,
    output bcd_digit_t q,
    output logic       is_zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= bcd_clamp(d_in);
        end else if (step) begin
            q <= (q == '0) ? BCD_MAX : bcd_digit_t'(q - 4'd1);
        end
    end

    assign is_zero = (q == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded BCD countdown timer with prescaled tick, parallel preset, optional
// auto-reload and a terminal-count pulse. Digit encoding matches the mod-10 up-counter.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned TICK_DIV    = 65536,
    parameter int unsigned AUTO_RELOAD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   count,
    output logic                  zero,
    output logic                  done,
    output logic                  bcd_err
);

    localparam int unsigned CW = BCD_W * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]     presc;
    logic [CW-1:0]     stored;
    logic [CW-1:0]     preset_clamped_c;
    logic              preset_bad_c;
    logic              tick_c;
    logic              dec_c;
    logic              reload_c;
    logic              digit_load_c;
    logic [CW-1:0]     digit_src_c;
    logic [DIGITS-1:0] digit_zero;
    logic [DIGITS-1:0] step_c;
    logic              borrow_c;
    logic              upper_zero_c;
    logic              last_one_c;

    // Per-nibble clamp of the incoming preset and illegal-digit detection.
    always_comb begin
        preset_clamped_c = '0;
        preset_bad_c     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            preset_clamped_c[BCD_W*i +: BCD_W] = bcd_clamp(preset[BCD_W*i +: BCD_W]);
            preset_bad_c = preset_bad_c | (preset[BCD_W*i +: BCD_W] > BCD_MAX);
        end
    end

    assign zero     = &digit_zero;
    assign tick_c   = en && (presc == PW'(TICK_DIV - 1));
    assign dec_c    = tick_c && !load && !zero;
    assign reload_c = (AUTO_RELOAD != 0) && tick_c && !load && zero;

    assign digit_load_c = load || reload_c;
    assign digit_src_c  = load ? preset_clamped_c : stored;

    // Borrow chain: digit i steps only when every lower digit already reads 0.
    // upper_zero flags the value 1, i.e. the decrement that lands on zero.
    always_comb begin
        step_c       = '0;
        borrow_c     = 1'b1;
        upper_zero_c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            step_c[i] = dec_c && borrow_c;
            borrow_c  = borrow_c && digit_zero[i];
            if (i > 0) begin
                upper_zero_c = upper_zero_c && digit_zero[i];
            end
        end
        last_one_c = (count[BCD_W-1:0] == 4'd1) && upper_zero_c;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk     (clk),
            .rst     (rst),
            .load    (digit_load_c),
            .d_in    (digit_src_c[BCD_W*g +: BCD_W]),
            .step    (step_c[g]),
            .q       (count[BCD_W*g +: BCD_W]),
            .is_zero (digit_zero[g])
        );
    end

    // Prescaler, stored preset, terminal-count pulse and load error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            stored  <= '0;
            done    <= 1'b0;
            bcd_err <= 1'b0;
        end else if (load) begin
            presc   <= '0;
            stored  <= preset_clamped_c;
            done    <= 1'b0;
            bcd_err <= preset_bad_c;
        end else begin
            done <= dec_c && last_one_c;
            if (en) begin
                presc <= tick_c ? '0 : presc + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench: two counter configurations driven in lockstep against an integer model.
module tb_bcd_down_counter;

    localparam int unsigned TD_B = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic [15:0] preset = '0;

    logic [15:0] count_a, count_b;
    logic        zero_a, zero_b, done_a, done_b, err_a, err_b;

    bcd_down_counter #(.DIGITS(4), .TICK_DIV(1), .AUTO_RELOAD(0)) u_dut_a (
        .clk(clk), .rst(rst), .load(load), .preset(preset), .en(en),
        .count(count_a), .zero(zero_a), .done(done_a), .bcd_err(err_a)
    );

    bcd_down_counter #(.DIGITS(4), .TICK_DIV(TD_B), .AUTO_RELOAD(1)) u_dut_b (
        .clk(clk), .rst(rst), .load(load), .preset(preset), .en(en),
        .count(count_b), .zero(zero_b), .done(done_b), .bcd_err(err_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] count;
        logic        zero;
        logic        done;
        logic        err;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t ea, eb;
    int   tests = 0;
    int   fails = 0;

    // Reference model: counter value as a plain decimal integer.
    int m_val[2]    = '{0, 0};
    int m_stored[2] = '{0, 0};
    int m_pc[2]     = '{0, 0};
    bit m_done[2]   = '{0, 0};
    bit m_err[2]    = '{0, 0};
    int m_td[2]     = '{1, TD_B};
    bit m_ar[2]     = '{0, 1};

    function automatic int clamp_val(input logic [15:0] p);
        int v = 0;
        int w = 1;
        for (int i = 0; i < 4; i++) begin
            int n = int'(p[4*i +: 4]);
            v += ((n > 9) ? 9 : n) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic bit any_bad(input logic [15:0] p);
        bit b = 0;
        for (int i = 0; i < 4; i++) b |= (p[4*i +: 4] > 4'd9);
        return b;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_edge(input int m, input bit r, input bit ld, input logic [15:0] p, input bit e);
        if (r) begin
            m_val[m] = 0; m_stored[m] = 0; m_pc[m] = 0; m_done[m] = 0; m_err[m] = 0;
        end else if (ld) begin
            m_val[m] = clamp_val(p); m_stored[m] = m_val[m];
            m_pc[m] = 0; m_done[m] = 0; m_err[m] = any_bad(p);
        end else begin
            m_done[m] = 0;
            if (e) begin
                if (m_pc[m] == m_td[m] - 1) begin
                    m_pc[m] = 0;
                    if (m_val[m] != 0) begin
                        m_val[m] -= 1;
                        m_done[m] = (m_val[m] == 0);
                    end else if (m_ar[m]) begin
                        m_val[m] = m_stored[m];
                    end
                end else begin
                    m_pc[m] += 1;
                end
            end
        end
    endtask

    function automatic obs_t expect_obs(input int m);
        obs_t o;
        o.count = to_bcd(m_val[m]);
        o.zero  = (m_val[m] == 0);
        o.done  = m_done[m];
        o.err   = m_err[m];
        return o;
    endfunction

    // One clock: apply inputs, advance both models, queue what each DUT must show.
    task automatic cyc(input bit r, input bit ld, input logic [15:0] p, input bit e);
        @(negedge clk);
        rst = r; load = ld; preset = p; en = e;
        for (int m = 0; m < 2; m++) model_edge(m, r, ld, p, e);
        q_a.push_back(expect_obs(0));
        q_b.push_back(expect_obs(1));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare each DUT against the oldest queued expectation after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                ea = q_a.pop_front();
                check("a_count", 32'(count_a), 32'(ea.count));
                check("a_zero",  32'(zero_a),  32'(ea.zero));
                check("a_done",  32'(done_a),  32'(ea.done));
                check("a_bcd_err", 32'(err_a), 32'(ea.err));
            end
            if (q_b.size() > 0) begin
                eb = q_b.pop_front();
                check("b_count", 32'(count_b), 32'(eb.count));
                check("b_zero",  32'(zero_b),  32'(eb.zero));
                check("b_done",  32'(done_b),  32'(eb.done));
                check("b_bcd_err", 32'(err_b), 32'(eb.err));
            end
        end
    end

    initial begin
        bit          r, ld, e;
        logic [15:0] p;

        cyc(1, 0, 16'h0000, 0);
        cyc(1, 0, 16'h0000, 0);
        repeat (20) cyc(0, 0, 16'h0000, 1);

        cyc(0, 1, 16'h0012, 1);
        repeat (20) cyc(0, 0, 16'h0000, 1);

        cyc(0, 1, 16'h1000, 1);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 1, 16'h0A5F, 0);
        cyc(0, 0, 16'h0000, 0);
        cyc(0, 1, 16'h0003, 0);
        repeat (2) cyc(0, 0, 16'h0000, 1);

        cyc(0, 1, 16'h0005, 1);
        repeat (2) cyc(0, 0, 16'h0000, 1);
        repeat (3) cyc(0, 0, 16'h0000, 0);
        repeat (12) cyc(0, 0, 16'h0000, 1);
        cyc(0, 1, 16'h0042, 1);
        cyc(0, 0, 16'h0000, 1);

        cyc(0, 1, 16'h0002, 1);
        repeat (20) cyc(0, 0, 16'h0000, 1);

        cyc(0, 1, 16'h0500, 1);
        repeat (3) cyc(0, 0, 16'h0000, 1);
        cyc(1, 0, 16'h0000, 1);
        repeat (8) cyc(0, 0, 16'h0000, 1);

        repeat (3000) begin
            r  = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       p = 16'($urandom);
                1:       p = to_bcd(int'($urandom_range(0, 30)));
                default: p = to_bcd(int'($urandom_range(0, 9999)));
            endcase
            cyc(r, ld, p, e);
        end

        repeat (2) @(negedge clk);
        tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d/%0d expectations left unchecked, required 0", q_a.size(), q_b.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
